// File: rtl/inst_fetch_queue.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// inst_fetch_queue
//
// Fetch stage sitting directly in front of the core's decode/control logic.
// It walks a sequential fetch PC, reads instruction words from a
// variable-latency instruction memory over a req/ack handshake, and buffers
// {pc, instruction} pairs in a small FIFO. Decode drains the FIFO through a
// valid/ready interface. A redirect (taken branch, jal, jalr) empties the
// queue and restarts fetching at the new PC.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous, active-low reset
//   redirect_i     flush the queue and restart fetch at redirect_pc_i
//   redirect_pc_i  new fetch PC, low two bits ignored
//   mem_req_o      instruction memory read request
//   mem_addr_o     word-aligned read address, stable while mem_req_o is high
//   mem_ack_i      read complete, mem_rdata_i valid this cycle
//   mem_rdata_i    instruction word returned by memory
//   inst_valid_o   queue head holds a valid instruction
//   inst_o         head instruction word
//   inst_pc_o      PC of the head instruction
//   inst_ready_i   decode takes the head when inst_valid_o is also high
// ---------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // IDLE  : no request on the bus
  // REQ   : request outstanding, returned data is enqueued
  // DRAIN : request outstanding but made stale by a redirect; data dropped
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [31:0]     fetch_pc;
  logic [31:0]     fetch_pc_next;
  logic [31:0]     req_addr;
  logic            load_addr;

  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;

  logic            push;
  logic            pop;

  logic [31:0]     pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];

  logic            unused_pc_bits;

  // The low PC bits are forced to zero, so the incoming ones are never used.
  assign unused_pc_bits = ^redirect_pc_i[1:0];

  // Outputs come straight from registered state so nothing from the memory
  // read data reaches decode combinationally. mem_req_o is decoded from the
  // state register, which means an asynchronous reset drops it immediately.
  assign mem_req_o    = (state != IDLE);
  assign mem_addr_o   = req_addr;
  assign inst_valid_o = (count != '0);
  assign inst_o       = inst_mem[rd_ptr];
  assign inst_pc_o    = pc_mem[rd_ptr];

  // Next-state and queue bookkeeping. A redirect has highest priority: it
  // cancels any push and pop happening in the same cycle and empties the
  // queue. Because a request is only issued while a slot is free and at most
  // one request is ever outstanding, a push can never find the FIFO full.
  // load_addr marks every transition that starts a fresh request, which is
  // the only time the bus address may change.
  always_comb begin
    state_next    = state;
    load_addr     = 1'b0;
    push          = (state == REQ) && mem_ack_i && !redirect_i;
    pop           = inst_valid_o && inst_ready_i && !redirect_i;
    fetch_pc_next = fetch_pc;
    count_next    = count;

    if (redirect_i) begin
      count_next    = '0;
      fetch_pc_next = {redirect_pc_i[31:2], 2'b00};
    end else begin
      count_next = count + CW'(push) - CW'(pop);
      if (push) begin
        fetch_pc_next = fetch_pc + 32'd4;
      end
    end

    case (state)
      IDLE: begin
        if (!redirect_i && (count < CW'(DEPTH))) begin
          state_next = REQ;
          load_addr  = 1'b1;
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          if (redirect_i || (count_next < CW'(DEPTH))) begin
            state_next = REQ;
            load_addr  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (redirect_i) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_ack_i) begin
          state_next = REQ;
          load_addr  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control state: FSM, fetch PC, bus address and queue pointers. While a
  // request waits for its ack the address register is left alone, even when
  // a redirect moves fetch_pc, so the memory always sees a stable address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      count    <= count_next;
      if (load_addr) begin
        req_addr <= fetch_pc_next;
      end
      if (redirect_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
    end
  end

  // FIFO storage. It is cleared on reset so the head outputs read zero until
  // the first instruction arrives. In REQ, fetch_pc always equals the address
  // on the bus, so it is the PC of the word being returned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      inst_mem[wr_ptr] <= mem_rdata_i;
    end
  end

endmodule
